// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default geometry of the
// program RAM, the halt opcode and the fetch FSM state encoding.
package fetch_pkg;

    // Default program RAM geometry: 64 words of 16 bits.
    localparam int unsigned FETCH_ADDR_W = 6;
    localparam int unsigned FETCH_DATA_W = 16;

    // Opcode that stops fetching when the halt feature is built in.
    localparam logic [15:0] FETCH_HALT_WORD = 16'hFFFF;

    // Fetch FSM: running normally, or parked after a HALT opcode.
    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO holding {pc, instr} pairs returned by the program RAM.
// The head is presented combinationally from storage. Flush wins over push and
// pop in the same cycle. A push into a full FIFO or a pop from an empty FIFO is
// ignored, although the fetch stage never requests either.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_instr_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [1:0]        count_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_instr_o
);

    logic [ADDR_W-1:0] pc_mem_q    [2];
    logic [DATA_W-1:0] instr_mem_q [2];
    logic              rd_ptr_q;
    logic              rd_ptr_d;
    logic              wr_ptr_q;
    logic              wr_ptr_d;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              wr_en_s;
    logic              rd_en_s;

    // Qualified write/read strobes; flush suppresses both.
    assign wr_en_s = push_i & ~flush_i & (count_q != 2'd2);
    assign rd_en_s = pop_i  & ~flush_i & (count_q != 2'd0);

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            rd_ptr_d = rd_ptr_q ^ rd_en_s;
            wr_ptr_d = wr_ptr_q ^ wr_en_s;
            count_d  = count_q + {1'b0, wr_en_s} - {1'b0, rd_en_s};
        end
    end

    // Pointer, occupancy and storage registers; storage clears on reset so the
    // head reads as zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pc_mem_q[i]    <= {ADDR_W{1'b0}};
                instr_mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (wr_en_s) begin
                pc_mem_q[wr_ptr_q]    <= push_pc_i;
                instr_mem_q[wr_ptr_q] <= push_instr_i;
            end
        end
    end

    assign count_o      = count_q;
    assign empty_o      = (count_q == 2'd0);
    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];

endmodule : fetch_skid_fifo

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage sitting directly behind the 64x16 program RAM.
// Owns the PC, drives the RAM read address, absorbs the RAM's one-cycle read
// latency through a two-entry skid FIFO and hands instructions to decode over
// a valid/ready handshake. Redirects from execute flush everything in flight.
//
// Build option: define IFU_HALT_EN to make HALT_WORD stop fetching (FSM enters
// S_HALT, halted rises once the HALT word has been handed to decode). Without
// it HALT_WORD is an ordinary instruction and halted stays 0.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = FETCH_ADDR_W,
    parameter int unsigned       DATA_W    = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter logic [DATA_W-1:0] HALT_WORD = FETCH_HALT_WORD
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

`ifdef IFU_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] req_pc_q;
    logic [ADDR_W-1:0] req_pc_d;
    logic              inflight_q;
    logic              inflight_d;
    logic              halted_q;
    logic              halted_d;

    logic [1:0]        fifo_count_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              pop_s;
    logic              flush_s;
    logic [2:0]        occ_s;
    logic              issue_s;
    logic              halt_hit_s;
    logic              halt_out_s;

    // A transfer to decode happens whenever the head is valid and decode is
    // ready; it counts as accepted even if a redirect flushes the same cycle.
    assign pop_s   = ~fifo_empty_s & out_ready;
    assign flush_s = redir_valid;

    // The RAM word for the previous issue lands now; a redirect discards it.
    assign push_s  = inflight_q & ~redir_valid;

    // Occupancy after this cycle's transfer, counting the word still returning.
    // Netting out the pop lets the stage sustain one instruction per cycle
    // while guaranteeing buffer + in-flight never exceeds two.
    assign occ_s = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};

    // A returning HALT word stops issue in the same cycle, so nothing behind it
    // is ever in flight.
    assign halt_hit_s = HALT_EN & push_s & (mem_rdata == HALT_WORD);

    // The HALT word leaving the buffer: it is always the last word while parked.
    assign halt_out_s = HALT_EN & pop_s & (out_instr == HALT_WORD);

    assign issue_s = (state_q == S_RUN) & ~redir_valid & ~halt_hit_s & (occ_s < 3'd2);

    // Next-state for FSM, PC, in-flight tracking and the halted flag.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        halted_d   = halted_q;
        case (state_q)
            S_RUN: begin
                if (redir_valid) begin
                    pc_d     = redir_pc;
                    halted_d = 1'b0;
                    state_d  = S_RUN;
                end else begin
                    if (issue_s) begin
                        pc_d       = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        req_pc_d   = pc_q;
                        inflight_d = 1'b1;
                    end else begin
                        pc_d       = pc_q;
                        inflight_d = 1'b0;
                    end
                    if (halt_hit_s) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_HALT: begin
                if (redir_valid) begin
                    pc_d     = redir_pc;
                    halted_d = 1'b0;
                    state_d  = S_RUN;
                end else if (halt_out_s) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    halted_d = halted_q;
                    state_d  = S_HALT;
                end
            end
            default: begin
                state_d  = S_RUN;
                halted_d = 1'b0;
            end
        endcase
    end

    // State registers; reset overrides any pending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
        end
    end

    fetch_skid_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_s),
        .push_pc_i    (req_pc_q),
        .push_instr_i (mem_rdata),
        .pop_i        (pop_s),
        .flush_i      (flush_s),
        .count_o      (fifo_count_s),
        .empty_o      (fifo_empty_s),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr)
    );

    // The RAM address is the PC register itself; the RAM samples it each edge
    // and the returned word is kept only when that edge was an issue.
    assign mem_addr  = pc_q;
    assign mem_we    = 1'b0;
    assign out_valid = ~fifo_empty_s;
    assign halted    = halted_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A behavioural 64x16 synchronous RAM
// feeds the DUT; expected {pc, instr} pairs are queued as fetch is steered and
// popped on every decode transfer. Handles both IFU_HALT_EN builds.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [5:0]  pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_rdata = 16'h0000;
    logic        redir_valid = 1'b0;
    logic [5:0]  redir_pc = 6'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [5:0]  out_pc;
    logic        halted;

    logic [15:0] ram [64];
    exp_t        sb_q [$];
    logic [5:0]  next_pc = 6'd0;
    int          total = 0;
    int          bad = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Program RAM: one-cycle synchronous read.
    always @(posedge clk) mem_rdata <= ram[mem_addr];

    // Queue the next sequential word as expected output.
    task automatic push_next();
        exp_t e;
        e.pc    = next_pc;
        e.instr = ram[next_pc];
        sb_q.push_back(e);
        next_pc = next_pc + 6'd1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_pc !== 6'd0 || out_instr !== 16'h0000 ||
            halted !== 1'b0 || mem_addr !== 6'd0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL reset: valid=%b pc=%0d instr=%h halted=%b addr=%0d we=%b, expected 0 0 0000 0 0 0",
                     out_valid, out_pc, out_instr, halted, mem_addr, mem_we);
        end
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_stream();
        exp_t e;
        for (int i = 0; i < 8; i++) push_next();
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_latency: out_valid=%b one cycle after reset, expected 0", out_valid);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stream_gap: out_valid=%b at cycle %0d, expected 1", out_valid, c + 2);
            end else begin
                e = sb_q.pop_front();
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL stream_data: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   got = 0;
        logic rdy;
        for (int i = 0; i < 20; i++) push_next();
        for (int c = 0; c < 60 && got < 20; c++) begin
            @(negedge clk);
            rdy = !(c >= 3 && c < 8);
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_valid: out_valid=%b at cycle %0d, expected 1", out_valid, c);
            end
            if (!rdy && sb_q.size() > 0) begin
                total++;
                if (out_pc !== sb_q[0].pc || out_instr !== sb_q[0].instr ||
                    mem_addr !== sb_q[0].pc + 6'd2) begin
                    bad++;
                    $display("FAIL bp_hold: got pc=%0d instr=%h addr=%0d, expected pc=%0d instr=%h addr=%0d",
                             out_pc, out_instr, mem_addr, sb_q[0].pc, sb_q[0].instr, sb_q[0].pc + 6'd2);
                end
            end
            if (out_valid === 1'b1 && rdy) begin
                e = sb_q.pop_front();
                got++;
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL bp_data: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
            out_ready = rdy;
        end
        if (got < 20) begin
            total++;
            bad++;
            $display("FAIL bp_timeout: got %0d transfers, expected 20", got);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        int   got = 0;
        for (int i = 0; i < 40; i++) push_next();
        for (int c = 0; c < 80 && got < 40; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                e = sb_q.pop_front();
                got++;
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL wrap_data: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
            out_ready = 1'b1;
        end
        if (got < 40) begin
            total++;
            bad++;
            $display("FAIL wrap_timeout: got %0d transfers, expected 40", got);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_redirect();
        exp_t e;
        int   got = 0;
        push_next();
        @(negedge clk);
        e = sb_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
            bad++;
            $display("FAIL redir_sametx: got valid=%b pc=%0d instr=%h, expected valid=1 pc=%0d instr=%h",
                     out_valid, out_pc, out_instr, e.pc, e.instr);
        end
        redir_valid = 1'b1;
        redir_pc    = 6'd40;
        out_ready   = 1'b1;
        sb_q.delete();
        next_pc = 6'd40;
        for (int i = 0; i < 6; i++) push_next();
        @(negedge clk);
        redir_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || mem_addr !== 6'd40) begin
            bad++;
            $display("FAIL redir_flush: got valid=%b addr=%0d, expected valid=0 addr=40", out_valid, mem_addr);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_gap: out_valid=%b two cycles after redirect, expected 0", out_valid);
        end
        for (int c = 0; c < 20 && got < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL redir_latency: out_valid=%b three cycles after redirect, expected 1", out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                e = sb_q.pop_front();
                got++;
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL redir_data: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
            out_ready = 1'b1;
        end
        if (got < 6) begin
            total++;
            bad++;
            $display("FAIL redir_timeout: got %0d transfers, expected 6", got);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_halt();
        exp_t e;
        int   got = 0;
        int   n;
`ifdef IFU_HALT_EN
        n = 6;
`else
        n = 8;
`endif
        ram[5] = 16'hFFFF;
        @(negedge clk);
        redir_valid = 1'b1;
        redir_pc    = 6'd0;
        out_ready   = 1'b0;
        sb_q.delete();
        next_pc = 6'd0;
        for (int i = 0; i < n; i++) push_next();
        @(negedge clk);
        redir_valid = 1'b0;
        for (int c = 0; c < 30 && got < n; c++) begin
            @(negedge clk);
            total++;
            if (halted !== 1'b0) begin
                bad++;
                $display("FAIL halt_early: halted=%b before HALT transfer, expected 0", halted);
            end
            if (out_valid === 1'b1) begin
                e = sb_q.pop_front();
                got++;
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL halt_data: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
            out_ready = 1'b1;
        end
        if (got < n) begin
            total++;
            bad++;
            $display("FAIL halt_timeout: got %0d transfers, expected %0d", got, n);
        end
`ifdef IFU_HALT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (halted !== 1'b1 || out_valid !== 1'b0 || mem_addr !== 6'd6) begin
                bad++;
                $display("FAIL halt_park: got halted=%b valid=%b addr=%0d, expected 1 0 6",
                         halted, out_valid, mem_addr);
            end
        end
        @(negedge clk);
        redir_valid = 1'b1;
        redir_pc    = 6'd0;
        sb_q.delete();
        next_pc = 6'd0;
        for (int i = 0; i < 3; i++) push_next();
        @(negedge clk);
        redir_valid = 1'b0;
        total++;
        if (halted !== 1'b0 || out_valid !== 1'b0 || mem_addr !== 6'd0) begin
            bad++;
            $display("FAIL halt_resume: got halted=%b valid=%b addr=%0d, expected 0 0 0",
                     halted, out_valid, mem_addr);
        end
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                e = sb_q.pop_front();
                got++;
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL halt_resume_data: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
            out_ready = 1'b1;
        end
        if (got < 3) begin
            total++;
            bad++;
            $display("FAIL halt_resume_timeout: got %0d transfers, expected 3", got);
        end
`endif
        @(negedge clk);
        out_ready = 1'b0;
        ram[5] = 16'hA005;
    endtask

    task automatic test_reset_midop();
        exp_t e;
        int   got = 0;
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 6'd40;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || mem_addr !== 6'd0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL rst_midop: got valid=%b addr=%0d halted=%b, expected 0 0 0",
                     out_valid, mem_addr, halted);
        end
        rst         = 1'b0;
        redir_valid = 1'b0;
        out_ready   = 1'b1;
        sb_q.delete();
        next_pc = 6'd0;
        for (int i = 0; i < 6; i++) push_next();
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_midop_latency: out_valid=%b one cycle after reset, expected 0", out_valid);
        end
        for (int c = 0; c < 20 && got < 6; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                e = sb_q.pop_front();
                got++;
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL rst_midop_data: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
            out_ready = 1'b1;
        end
        if (got < 6) begin
            total++;
            bad++;
            $display("FAIL rst_midop_timeout: got %0d transfers, expected 6", got);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 16'hA000 + 16'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_redirect();
        test_halt();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_instr_fetch_unit
